ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter INHIBIT_US, default 100, duration the host holds PS/2 clock low before each transfer.
REQ-003 Parameter TIMEOUT_MS, default 15, watchdog limit for a whole transfer; used only with PS2_TX_TIMEOUT_EN.
REQ-004 One clock; reset is asynchronous and active-low. CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 tx_valid  in  1  command byte request.
REQ-007 tx_data  in  8  command byte, e.g. 0xED set-LEDs or 0xFF reset.
REQ-008 tx_ready  out  1  block idle; a byte is accepted when tx_valid and tx_ready are both high.
REQ-009 busy  out  1  transfer in progress; the keyboard receiver ignores the line while busy is high.
REQ-010 done  out  1  one-cycle pulse: byte sent and device ACK received.
REQ-011 err  out  1  one-cycle pulse: missing ACK, or timeout.
REQ-012 ps2_clk_in  in  1  raw PS2_CLK pin level.
REQ-013 ps2_dat_in  in  1  raw PS2_DAT pin level.
REQ-014 ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release the pin (open drain).
REQ-015 ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release the pin (open drain).

Function
REQ-016 ps2_clk_in and ps2_dat_in SHALL pass through 2-FF synchronizers; a falling edge (fe) is synchronized clock 1 on one cycle and 0 on the next.
REQ-017 States SHALL be IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, RELEASE.
REQ-018 IDLE: tx_ready=1, both oe=0; on accept, latch tx_data, compute parity = ~^tx_data, and go to INHIBIT next cycle.
REQ-019 INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES = CLK_HZ/1_000_000*INHIBIT_US cycles (5000 at the defaults), then go to REQ.
REQ-020 REQ: both oe=1 (start bit) for 16 cycles, then clk_oe=0 with dat_oe held at 1, then go to DATA.
REQ-021 DATA: on each fe, dat_oe = ~byte[bit_cnt], LSB first, 3-bit bit_cnt; after the fe that drives bit 7, go to PARITY.
REQ-022 PARITY: on fe, dat_oe = ~parity, then go to STOP.
REQ-023 STOP: on fe, dat_oe=0 (stop bit = 1), then go to ACK.
REQ-024 ACK: on the next fe, sample synchronized data; 0 means ACK, so go to RELEASE; 1 means pulse err and go to IDLE.
REQ-025 RELEASE: wait until synchronized clock and data are both 1, then pulse done and go to IDLE.
REQ-026 busy SHALL equal (state != IDLE); tx_ready SHALL equal (state == IDLE).
REQ-027 tx_valid while busy SHALL be ignored and not queued; tx_data changes after accept SHALL have no effect.
REQ-028 done and err SHALL never be asserted in the same cycle.
REQ-029 tx_ready SHALL return high the cycle after the done or err pulse.

Reset
REQ-030 With reset_n=0, all outputs SHALL take their reset values immediately, independent of the clock: tx_ready=1, busy=0, done=0, err=0, ps2_clk_oe=0, ps2_dat_oe=0, state=IDLE, all counters 0.
REQ-031 Reset mid-transfer SHALL abort with no done or err pulse; the line is released at once.

Configuration
REQ-032 Macro PS2_TX_TIMEOUT_EN defined: a watchdog counts from accept; at TIMEOUT_MS*CLK_HZ/1000 cycles (750_000 at the defaults) in any non-IDLE state, pulse err, release both oe, and go to IDLE.
REQ-033 Macro PS2_TX_TIMEOUT_EN undefined: no watchdog exists; the FSM waits indefinitely for device clock edges.

Structure
REQ-034 Package ps2_pkg SHALL hold the state enum type, command constants (PS2_CMD_LED=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4) and the 16-cycle REQ length.
REQ-035 Sub-module ps2_sync_edge SHALL implement the 2-FF synchronizer and falling-edge detect; it is instantiated once per pin.

Verification
REQ-036 Bench SHALL use a behavioural device model that clocks at 12.5 kHz and ACKs. Send 0xED -> clk_oe high for 5000 cycles; line bits 1,0,1,1,0,1,1,1; parity 1; stop 1; one done pulse.
REQ-037 Send 0xF4 -> data bits 0,0,1,0,1,1,1,1; parity 0; done pulse; tx_ready back to 1.
REQ-038 Device model holds data high at the ACK edge -> err pulse, no done, state IDLE.
REQ-039 Device model never clocks: with PS2_TX_TIMEOUT_EN, err at cycle 750_000 and both oe=0; without it, busy stays 1.
REQ-040 reset_n low during DATA bit 3 -> both oe=0 before the next clock edge, tx_ready=1, no pulses.
REQ-041 tx_valid pulsed with 0x00 during a 0xED transfer -> only 0xED is transmitted, a single done pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter:
// FSM state type, common keyboard command bytes, request-phase length
// and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_DATA    = 3'd3,
        ST_PARITY  = 3'd4,
        ST_STOP    = 3'd5,
        ST_ACK     = 3'd6,
        ST_RELEASE = 3'd7
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_LED    = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

    // Cycles the host holds both lines low (start bit) before releasing clock.
    localparam int PS2_REQ_CYCLES = 16;

    // PS/2 frames use odd parity: data bits plus parity bit hold an odd count of ones.
    function automatic logic ps2_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 pin plus falling-edge detect.
// The flops reset to 1 because an idle open-drain PS/2 line floats high,
// so leaving reset does not fabricate an edge on an idle bus.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_fe
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize the pin and keep one older sample for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fe    = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (open-drain, device-clocked).
// Handshake: a byte is taken on a rising CLOCK_50 edge where tx_valid and
// tx_ready are both high; tx_ready is high only in IDLE, so requests made
// while busy are dropped, not queued. done/err are single-cycle results.
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a transfer that has
// not finished TIMEOUT_MS after accept.
// state exposes the FSM encoding for observation.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic [2:0] state
);

    localparam int INHIBIT_CYCLES = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int CNT_MAX = (INHIBIT_CYCLES > PS2_REQ_CYCLES) ? INHIBIT_CYCLES : PS2_REQ_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ps2_state_e       r_state;
    logic [7:0]       r_byte;
    logic             r_parity;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_cnt;
    logic             r_clk_oe;
    logic             r_dat_oe;

    logic w_clk_lvl;
    logic w_clk_fe;
    logic w_dat_lvl;
    logic w_dat_fe;
    logic w_accept;
    logic w_done;
    logic w_nack;
    logic w_timeout;
    logic w_wdog_err;

    ps2_sync_edge u_sync_clk (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset_n),
        .i_pin   (ps2_clk_in),
        .o_level (w_clk_lvl),
        .o_fe    (w_clk_fe)
    );

    ps2_sync_edge u_sync_dat (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset_n),
        .i_pin   (ps2_dat_in),
        .o_level (w_dat_lvl),
        .o_fe    (w_dat_fe)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = TIMEOUT_MS * (CLK_HZ / 1000);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wdog;

    // Watchdog: zero while idle, counts every cycle of an active transfer.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= '0;
        end else if (r_state == ST_IDLE) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end

    // Fires in the TIMEOUT_CYCLES-th cycle after accept.
    assign w_timeout = (r_state != ST_IDLE) && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_accept   = tx_valid && (r_state == ST_IDLE);
    assign w_done     = (r_state == ST_RELEASE) && w_clk_lvl && w_dat_lvl;
    assign w_nack     = (r_state == ST_ACK) && w_clk_fe && w_dat_lvl;
    // A successful finish wins over a watchdog expiring in the same cycle.
    assign w_wdog_err = w_timeout && !w_done;

    // Main transfer sequencer: inhibit, request-to-send, then shift the frame
    // out on device falling edges and collect the ACK.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_byte    <= '0;
            r_parity  <= 1'b0;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
        end else if (w_wdog_err) begin
            r_state  <= ST_IDLE;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    if (w_accept) begin
                        r_byte    <= tx_data;
                        r_parity  <= ps2_parity(tx_data);
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_clk_oe  <= 1'b1;
                        r_state   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        r_cnt    <= '0;
                        r_dat_oe <= 1'b1;
                        r_state  <= ST_REQ;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_REQ: begin
                    if (r_cnt == CNT_W'(PS2_REQ_CYCLES - 1)) begin
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b0;
                        r_state  <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_clk_fe) begin
                        r_dat_oe  <= ~r_byte[r_bit_cnt];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_clk_fe) begin
                        r_dat_oe <= ~r_parity;
                        r_state  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_clk_fe) begin
                        r_dat_oe <= 1'b0;
                        r_state  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (w_clk_fe) begin
                        r_state <= w_dat_lvl ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_clk_lvl && w_dat_lvl) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign done       = w_done;
    assign err        = w_nack || w_wdog_err;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign state      = r_state;

    // The data-line edge is not needed by the transmitter.
    logic w_unused;
    assign w_unused = w_dat_fe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx. A behavioural PS/2 device drives the
// open-drain bus; its clock is time-scaled (80 system cycles per period)
// so the whole run stays short.
module tb_ps2_host_tx;

    localparam int CLK_HZ     = 10_000_000;
    localparam int INHIBIT_US = 100;
    localparam int TIMEOUT_MS = 1;
    localparam int INH_CYC    = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TO_CYC     = TIMEOUT_MS * CLK_HZ / 1000;
    localparam int HALF       = 40;
    localparam int WAIT_TMO   = 5000;

    logic       CLOCK_50;
    logic       reset_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic [2:0] state;

    logic dev_clk;
    logic dev_dat;
    logic bus_clk;
    logic bus_dat;

    assign bus_clk = ~(ps2_clk_oe | dev_clk);
    assign bus_dat = ~(ps2_dat_oe | dev_dat);

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ps2_clk_in (bus_clk),
        .ps2_dat_in (bus_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .state      (state)
    );

    // ---------------- clock / reset ----------------
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- monitor ----------------
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int inh_run  = 0;
    int req_run  = 0;
    int last_inh = 0;
    int last_req = 0;

    always @(negedge CLOCK_50) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (done === 1'b1 && err === 1'b1) both_cnt++;
        if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) begin
            inh_run++;
        end else if (inh_run != 0) begin
            last_inh = inh_run;
            inh_run  = 0;
        end
        if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1) begin
            req_run++;
        end else if (req_run != 0) begin
            last_req = req_run;
            req_run  = 0;
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame as the device sees it on the wire:
    // {stop, parity, data[7:0]}, parity makes the total count of ones odd.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] d);
        int t = 0;
        while (tx_ready !== 1'b1 && t < WAIT_TMO) begin
            @(negedge CLOCK_50);
            t++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
    endtask

    // Device side of one host-to-device frame. Samples each bit on its own
    // rising clock edge. stop_after < 10 abandons the frame right after that
    // falling edge, leaving the device clock low.
    task automatic dev_xfer(input bit ack, input int stop_after,
                            output logic [9:0] bits, output bit ok);
        int t = 0;
        bits = '0;
        ok   = 1'b1;
        while (!(bus_clk === 1'b1 && bus_dat === 1'b0) && t < WAIT_TMO) begin
            @(negedge CLOCK_50);
            t++;
        end
        if (t >= WAIT_TMO) begin
            ok = 1'b0;
            return;
        end
        repeat (HALF) @(negedge CLOCK_50);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b1;
            repeat (HALF / 2) @(negedge CLOCK_50);
            if (i == stop_after) return;
            repeat (HALF - HALF / 2) @(negedge CLOCK_50);
            dev_clk = 1'b0;
            bits[i] = bus_dat;
            repeat (HALF) @(negedge CLOCK_50);
        end
        repeat (HALF / 2) @(negedge CLOCK_50);
        dev_dat = ack;
        repeat (HALF / 2) @(negedge CLOCK_50);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        dev_clk = 1'b0;
        repeat (HALF / 2) @(negedge CLOCK_50);
        dev_dat = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done !== 1'b1 && t < 500) begin
            @(negedge CLOCK_50);
            t++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_ready_low_at_done"}, 32'(tx_ready), 32'd0);
        @(negedge CLOCK_50);
        check({tag, "_ready_after_done"}, 32'(tx_ready), 32'd1);
    endtask

    task automatic full_xfer(input string tag, input logic [7:0] d, output logic [9:0] got);
        int d0;
        int e0;
        bit ok;
        logic [9:0] exp_f;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d);
        exp_q.push_back(frame_of(d));
        dev_xfer(1'b1, 10, got, ok);
        check({tag, "_dev_saw_request"}, 32'(ok), 32'd1);
        wait_done(tag);
        repeat (3) @(negedge CLOCK_50);
        exp_f = exp_q.pop_front();
        check({tag, "_frame"}, 32'(got), 32'(exp_f));
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_err_count"}, 32'(err_cnt - e0), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [9:0] got;
        logic [7:0] rb;
        bit ok;
        int d0;
        int e0;
        int n;

        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b0;
        dev_dat  = 1'b0;
        repeat (4) @(negedge CLOCK_50);

        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // Set-LEDs command: timing of inhibit and request phases, exact wire bits.
        full_xfer("ed", 8'hED, got);
        check("ed_wire_literal", 32'(got), 32'h3ED);
        check("ed_inhibit_len", 32'(last_inh), 32'(INH_CYC));
        check("ed_req_len", 32'(last_req), 32'd16);

        // Enable command.
        full_xfer("f4", 8'hF4, got);
        check("f4_wire_literal", 32'(got), 32'h2F4);

        // Random bytes against the frame model.
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom_range(255, 0));
            full_xfer("rand", rb, got);
        end

        // Device withholds ACK: err pulse, no done, back to IDLE.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hFF);
        exp_q.push_back(frame_of(8'hFF));
        dev_xfer(1'b0, 10, got, ok);
        repeat (10) @(negedge CLOCK_50);
        check("nack_frame", 32'(got), 32'(exp_q.pop_front()));
        check("nack_err_count", 32'(err_cnt - e0), 32'd1);
        check("nack_done_count", 32'(done_cnt - d0), 32'd0);
        check("nack_state_idle", 32'(state), 32'd0);
        check("nack_ready", 32'(tx_ready), 32'd1);

        // Requests while busy are dropped and the latched byte is unaffected.
        d0 = done_cnt;
        send(8'hED);
        exp_q.push_back(frame_of(8'hED));
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        repeat (20) @(negedge CLOCK_50);
        tx_valid = 1'b0;
        dev_xfer(1'b1, 10, got, ok);
        wait_done("busyreq");
        check("busyreq_frame", 32'(got), 32'(exp_q.pop_front()));
        repeat (300) @(negedge CLOCK_50);
        check("busyreq_not_queued", 32'(busy), 32'd0);
        check("busyreq_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset while bit 3 is on the line: lines released before the next edge.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'($urandom_range(255, 0)));
        dev_xfer(1'b1, 3, got, ok);
        check("rstmid_in_data", 32'(state), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rstmid_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rstmid_ready", 32'(tx_ready), 32'd1);
        check("rstmid_pulses", 32'({done, err}), 32'd0);
        @(negedge CLOCK_50);
        dev_clk = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (50) @(negedge CLOCK_50);
        check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rstmid_no_err", 32'(err_cnt - e0), 32'd0);
        check("rstmid_idle", 32'(busy), 32'd0);

        // Device that never clocks.
        e0 = err_cnt;
        send(8'h55);
`ifdef PS2_TX_TIMEOUT_EN
        n = 1;
        while (err !== 1'b1 && n < TO_CYC + 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("wdog_err_cycle", 32'(n), 32'(TO_CYC));
        @(negedge CLOCK_50);
        check("wdog_oe_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check("wdog_state_idle", 32'(state), 32'd0);
`else
        n = 0;
        repeat (3000) @(negedge CLOCK_50);
        check("noclk_busy", 32'(busy), 32'd1);
        check("noclk_no_err", 32'(err_cnt - e0), 32'd0);
        check("noclk_not_ready", 32'(tx_ready), 32'd0);
`endif
        reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        check("never_done_and_err", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
